// File: rtl/mul_arb_sched.sv
// mul_arb_sched: two requesters share one signed 16x16 multiplier through a
// round-robin arbiter. The multiplier is a two-stage pipeline: operand
// register -> radix-4 Booth encoding -> Wallace carry-save tree -> sum/carry
// register -> final carry-propagate adder.
//
// Handshake: a transfer happens on a port when its valid and ready are both
// high at a rising clock edge. Producers hold valid and data until the
// transfer and never derive valid from ready; ready never depends on the
// data lines, only on valid, the pipeline occupancy and out_ready.

// -----------------------------------------------------------------------------
// booth_enc: radix-4 Booth recoding of b, producing eight 32-bit partial
// products of a (already shifted into position) and a carry-in vector holding
// the +1 that completes each two's-complement negation.
// -----------------------------------------------------------------------------
module booth_enc (
   input  logic [15:0]      a,
   input  logic [15:0]      b,
   output logic [7:0][31:0] pp,
   output logic [31:0]      cin
);

   logic [31:0] a_ext;

   assign a_ext = {{16{a[15]}}, a};

   for (genvar i = 0; i < 8; i++) begin : g_digit
      logic [2:0]  trip;
      logic        one;
      logic        two;
      logic        neg;
      logic [31:0] mag;

      // Overlapping triplet {b[2i+1], b[2i], b[2i-1]} with b[-1] = 0
      if (i == 0) begin : g_lsb
         assign trip = {b[1], b[0], 1'b0};
      end else begin : g_upper
         assign trip = b[2*i+1 : 2*i-1];
      end

      // Digit in {-2,-1,0,+1,+2}: magnitude select plus a sign flag.
      // neg is suppressed for the all-ones triplet so a zero digit stays zero.
      assign one = trip[1] ^ trip[0];
      assign two = (trip == 3'b011) | (trip == 3'b100);
      assign neg = trip[2] & ~(trip[1] & trip[0]);
      assign mag = one ? a_ext : (two ? (a_ext << 1) : 32'd0);

      // Negation is ~mag here; the matching +1 rides in cin at the same weight
      assign pp[i]      = (neg ? ~mag : mag) << (2 * i);
      assign cin[2*i]   = neg;
      assign cin[2*i+1] = 1'b0;
   end

endmodule

// -----------------------------------------------------------------------------
// wallace_tree: reduces nine 32-bit operands (8 partial products + carry-in
// vector) to a sum/carry pair with s + (c << 1) equal to their total mod 2^32.
// Levels: 9 -> 6 -> 4 -> 3 -> 2 using 3:2 carry-save adders.
// -----------------------------------------------------------------------------
module wallace_tree (
   input  logic [7:0][31:0] pp,
   input  logic [31:0]      cin,
   output logic [31:0]      s,
   output logic [31:0]      c
);

   // 3:2 compressor: upper half is the carry word (weight 2), lower the sum
   function automatic logic [63:0] csa(input logic [31:0] x,
                                       input logic [31:0] y,
                                       input logic [31:0] z);
      return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
   endfunction

   logic [31:0] s0, k0, s1, k1, s2, k2;
   logic [31:0] s3, k3, s4, k4;
   logic [31:0] s5, k5;
   logic [31:0] s6, k6;

   // Level 1: nine operands in three groups
   assign {k0, s0} = csa(pp[0], pp[1], pp[2]);
   assign {k1, s1} = csa(pp[3], pp[4], pp[5]);
   assign {k2, s2} = csa(pp[6], pp[7], cin);

   // Level 2: six operands (carries realigned to their true weight)
   assign {k3, s3} = csa(s0, k0 << 1, s1);
   assign {k4, s4} = csa(k1 << 1, s2, k2 << 1);

   // Level 3: four operands
   assign {k5, s5} = csa(s3, k3 << 1, s4);

   // Level 4: three operands down to the final pair
   assign {k6, s6} = csa(s5, k5 << 1, k4 << 1);

   assign s = s6;
   assign c = k6;

endmodule

// -----------------------------------------------------------------------------
// final_add: carry-propagate resolution of the registered sum/carry pair
// -----------------------------------------------------------------------------
module final_add (
   input  logic [31:0] s,
   input  logic [31:0] c,
   output logic [31:0] sum
);

   assign sum = s + (c << 1);

endmodule

// -----------------------------------------------------------------------------
// rr_arbiter: two-way round-robin grant with a 1-bit priority pointer. The
// pointer moves past whichever requester completed a transfer and holds
// otherwise. Readys are forced low while reset is asserted.
// -----------------------------------------------------------------------------
module rr_arbiter (
   input  logic clk,
   input  logic rst,
   input  logic valid0,
   input  logic valid1,
   input  logic accept_ok,
   output logic ready0,
   output logic ready1
);

   logic ptr;
   logic grant0;
   logic grant1;

   // Lone requester wins; on contention the pointer picks
   assign grant0 = valid0 & (~valid1 | ~ptr);
   assign grant1 = valid1 & (~valid0 |  ptr);

   assign ready0 = ~rst & accept_ok & grant0;
   assign ready1 = ~rst & accept_ok & grant1;

   // Priority pointer: after serving requester i the other one is favoured
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (valid0 & ready0) begin
         ptr <= 1'b1;
      end else if (valid1 & ready1) begin
         ptr <= 1'b0;
      end
   end

endmodule

// -----------------------------------------------------------------------------
// mul_arb_sched: top level
// -----------------------------------------------------------------------------
module mul_arb_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   output logic        req1_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_product,
   output logic        out_id,
   output logic        busy,
   output logic [15:0] done_cnt
);

   // Stage 1: operands and source of the accepted operation
   logic        v1;
   logic [15:0] a1;
   logic [15:0] b1;
   logic        id1;

   // Stage 2: carry-save result and source
   logic        v2;
   logic [31:0] s2;
   logic [31:0] c2;
   logic        id2;

   logic        load2;
   logic        accept_ok;
   logic        xfer0;
   logic        xfer1;
   logic        deliver;

   logic [7:0][31:0] pp;
   logic [31:0]      cin;
   logic [31:0]      tree_s;
   logic [31:0]      tree_c;

   // Stage 2 takes stage 1 whenever it is empty or its content leaves now;
   // stage 1 can then take a new operation if empty or advancing.
   assign load2     = ~v2 | out_ready;
   assign accept_ok = ~v1 | load2;

   assign xfer0   = req0_valid & req0_ready;
   assign xfer1   = req1_valid & req1_ready;
   assign deliver = v2 & out_ready;

   rr_arbiter u_arb (
      .clk       (clk),
      .rst       (rst),
      .valid0    (req0_valid),
      .valid1    (req1_valid),
      .accept_ok (accept_ok),
      .ready0    (req0_ready),
      .ready1    (req1_ready)
   );

   booth_enc u_booth (
      .a   (a1),
      .b   (b1),
      .pp  (pp),
      .cin (cin)
   );

   wallace_tree u_tree (
      .pp  (pp),
      .cin (cin),
      .s   (tree_s),
      .c   (tree_c)
   );

   final_add u_add (
      .s   (s2),
      .c   (c2),
      .sum (out_product)
   );

   // Stage 1 register: capture the granted request, empty out when advancing
   // with nothing new arriving
   always_ff @(posedge clk) begin
      if (rst) begin
         v1  <= 1'b0;
         a1  <= 16'd0;
         b1  <= 16'd0;
         id1 <= 1'b0;
      end else if (accept_ok) begin
         v1 <= xfer0 | xfer1;
         if (xfer1) begin
            a1  <= req1_a;
            b1  <= req1_b;
            id1 <= 1'b1;
         end else if (xfer0) begin
            a1  <= req0_a;
            b1  <= req0_b;
            id1 <= 1'b0;
         end
      end
   end

   // Stage 2 register: load tree output when free or draining; hold on stall
   always_ff @(posedge clk) begin
      if (rst) begin
         v2  <= 1'b0;
         s2  <= 32'd0;
         c2  <= 32'd0;
         id2 <= 1'b0;
      end else if (load2) begin
         v2  <= v1;
         s2  <= tree_s;
         c2  <= tree_c;
         id2 <= id1;
      end
   end

   // Delivered-result counter, wraps naturally at 16 bits
   always_ff @(posedge clk) begin
      if (rst) begin
         done_cnt <= 16'd0;
      end else if (deliver) begin
         done_cnt <= done_cnt + 16'd1;
      end
   end

   assign out_valid = v2;
   assign out_id    = id2;
   assign busy      = v1 | v2;

endmodule

// File: tb/tb_mul_arb_sched.sv
// Self-checking bench for mul_arb_sched: directed steps in one initial block,
// a negedge monitor with a scoreboard of expected {id, product} entries.
module tb_mul_arb_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0;
   logic [15:0] req0_a = 16'd0;
   logic [15:0] req0_b = 16'd0;
   logic        req0_ready;
   logic        req1_valid = 1'b0;
   logic [15:0] req1_a = 16'd0;
   logic [15:0] req1_b = 16'd0;
   logic        req1_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_product;
   logic        out_id;
   logic        busy;
   logic [15:0] done_cnt;

   int          checks = 0;
   int          failures = 0;

   logic [32:0] exp_q[$];
   logic [15:0] exp_cnt = 16'd0;
   logic        hold_prev = 1'b0;
   logic [32:0] prev_out = 33'd0;

   logic [15:0] bp_a [6] = '{16'h0007, 16'h8000, 16'h1234, 16'hFFFF, 16'h7FFF, 16'h00FF};
   logic [15:0] bp_b [6] = '{16'hFFFD, 16'h0002, 16'h0010, 16'h8000, 16'h7FFF, 16'hFF01};

   mul_arb_sched dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_ready  (req1_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .out_id      (out_id),
      .busy        (busy),
      .done_cnt    (done_cnt)
   );

   // Clock and time-limit watchdog
   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference product, independent of any Booth/tree structure
   function automatic logic [32:0] model(input logic id, input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic signed [31:0] p;
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      return {id, p};
   endfunction

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Monitor: protocol checks, scoreboard pop on delivery, push on transfer
   always @(negedge clk) begin
      if (rst) begin
         chk("reset_ready", {req1_ready, req0_ready}, 33'd0);
         exp_q.delete();
         exp_cnt   = 16'd0;
         hold_prev = 1'b0;
      end else begin
         chk("done_cnt", done_cnt, exp_cnt);
         chk("busy", busy, exp_q.size() != 0);
         chk("ready_rule", (req0_ready & req1_ready) | (req0_ready & ~req0_valid)
                           | (req1_ready & ~req1_valid), 33'd0);
         if (hold_prev) begin
            chk("stall_stable", {out_valid, out_id, out_product}, {1'b1, prev_out});
         end
         if (out_valid && out_ready) begin
            chk("sb_nonempty", exp_q.size() != 0, 33'd1);
            if (exp_q.size() != 0) begin
               chk("sb_result", {out_id, out_product}, exp_q.pop_front());
            end
            exp_cnt = exp_cnt + 16'd1;
         end
         if (req0_valid && req0_ready) exp_q.push_back(model(1'b0, req0_a, req0_b));
         if (req1_valid && req1_ready) exp_q.push_back(model(1'b1, req1_a, req1_b));
         hold_prev = out_valid && !out_ready;
         prev_out  = {out_id, out_product};
      end
   end

   // Driver tasks; all input changes happen 1 time unit after a rising edge
   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send_op(input logic p, input logic [15:0] a, input logic [15:0] b);
      int n;
      n = 0;
      if (p) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b;
      end
      @(negedge clk);
      while (!(p ? req1_ready : req0_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("send_timeout", 33'd0, 33'd1);
      @(posedge clk);
      #1;
      if (p) req1_valid = 1'b0;
      else   req0_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag, input logic [31:0] prod, input logic id);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {out_id, out_product}, {id, prod});
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || out_valid) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) chk("idle_timeout", 33'd0, 33'd1);
      @(posedge clk);
      #1;
   endtask

   // Directed sequence
   initial begin
      logic        got;
      logic        g;
      int          idx;
      int          cyc;
      int          sent;
      logic [32:0] exp0;
      logic [15:0] base;

      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 33'd0);
      chk("rst_busy", busy, 33'd0);
      chk("rst_done_cnt", done_cnt, 33'd0);
      chk("rst_out_id", out_id, 33'd0);
      chk("rst_product", out_product, 33'd0);

      // Single op 3 * -5 on requester 0, two-edge latency
      @(posedge clk); #1;
      out_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'hFFFB;
      @(negedge clk);
      chk("single_ready", {req1_ready, req0_ready}, 33'b01);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      chk("single_lat1", {busy, out_valid}, 33'b10);
      @(posedge clk); #1;
      @(negedge clk);
      chk("single_valid", out_valid, 33'd1);
      chk("single_result", {out_id, out_product}, {1'b0, 32'hFFFFFFF1});
      @(posedge clk); #1;
      @(negedge clk);
      chk("single_cnt", done_cnt, 33'd1);
      @(posedge clk); #1;

      // Extremes
      send_op(1'b0, 16'h8000, 16'h8000);
      wait_out("ext_min_min", 32'h40000000, 1'b0);
      send_op(1'b1, 16'h7FFF, 16'h8000);
      wait_out("ext_max_min", 32'hC0008000, 1'b1);
      send_op(1'b0, 16'hFFFF, 16'hFFFF);
      wait_out("ext_m1_m1", 32'h00000001, 1'b0);
      send_op(1'b1, 16'h0000, 16'h1234);
      wait_out("ext_zero", 32'h00000000, 1'b1);
      wait_idle();

      // Fairness: both valid continuously, grants alternate starting with 0
      do_reset();
      out_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 16'($urandom_range(0, 65535)); req0_b = 16'($urandom_range(0, 65535));
      req1_valid = 1'b1; req1_a = 16'($urandom_range(0, 65535)); req1_b = 16'($urandom_range(0, 65535));
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         g = req1_ready;
         chk("fair_grant", {req1_ready, req0_ready}, (i % 2 == 0) ? 33'b01 : 33'b10);
         if (i >= 2) chk("fair_rate", out_valid, 33'd1);
         @(posedge clk); #1;
         if (g) begin
            req1_a = 16'($urandom_range(0, 65535)); req1_b = 16'($urandom_range(0, 65535));
         end else begin
            req0_a = 16'($urandom_range(0, 65535)); req0_b = 16'($urandom_range(0, 65535));
         end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle();

      // Backpressure: six ops, out_ready low for four edges
      base = exp_cnt;
      exp0 = model(1'b0, bp_a[0], bp_b[0]);
      out_ready = 1'b0;
      idx = 0;
      cyc = 0;
      req0_valid = 1'b1; req0_a = bp_a[0]; req0_b = bp_b[0];
      while (idx < 6 && cyc < 40) begin
         @(negedge clk);
         got = req0_ready;
         if (cyc == 2 || cyc == 3) begin
            chk("bp_readys", {req1_ready, req0_ready}, 33'd0);
            chk("bp_full", {busy, out_valid}, 33'b11);
            chk("bp_head", {out_id, out_product}, exp0);
         end
         @(posedge clk); #1;
         if (got) begin
            idx++;
            if (idx < 6) begin
               req0_a = bp_a[idx]; req0_b = bp_b[idx];
            end else begin
               req0_valid = 1'b0;
            end
         end
         if (cyc == 3) out_ready = 1'b1;
         cyc++;
      end
      req0_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_sent", idx, 33'd6);
      wait_idle();
      @(negedge clk);
      chk("bp_delivered", done_cnt, base + 16'd6);
      chk("bp_queue_empty", exp_q.size(), 33'd0);
      @(posedge clk); #1;

      // Reset mid-operation with both stages full; ptr left pointing at 1
      out_ready = 1'b0;
      send_op(1'b0, 16'h0011, 16'h0022);
      send_op(1'b0, 16'h0033, 16'h0044);
      @(negedge clk);
      chk("rm_full", {busy, out_valid}, 33'b11);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rm_out_valid", out_valid, 33'd0);
      chk("rm_busy", busy, 33'd0);
      chk("rm_done_cnt", done_cnt, 33'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 16'h0101; req0_b = 16'h0202;
      req1_valid = 1'b1; req1_a = 16'h0303; req1_b = 16'h0404;
      @(negedge clk);
      chk("rm_ptr_reset", {req1_ready, req0_ready}, 33'b01);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      chk("rm_ptr_next", {req1_ready, req0_ready}, 33'b10);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      wait_idle();

      // Counter wrap: 65536 deliveries from reset
      do_reset();
      out_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 16'($urandom_range(0, 65535)); req0_b = 16'($urandom_range(0, 65535));
      sent = 0;
      cyc = 0;
      while (sent < 65536 && cyc < 70000) begin
         @(negedge clk);
         got = req0_ready;
         @(posedge clk); #1;
         if (got) begin
            sent++;
            if (sent < 65536) begin
               req0_a = 16'($urandom_range(0, 65535)); req0_b = 16'($urandom_range(0, 65535));
            end else begin
               req0_valid = 1'b0;
            end
         end
         cyc++;
      end
      req0_valid = 1'b0;
      chk("wrap_sent", sent, 33'd65536);
      wait_idle();
      @(negedge clk);
      chk("wrap_zero", done_cnt, 33'h0000);
      @(posedge clk); #1;
      send_op(1'b1, 16'h0002, 16'h0003);
      wait_idle();
      @(negedge clk);
      chk("wrap_one", done_cnt, 33'h0001);
      chk("final_queue_empty", exp_q.size(), 33'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
